hilo_muldiv: RTL
================

// Module: hilo_muldiv
// PURPOSE
//  Multi-cycle MIPS multiply/divide engine. It is the write-side producer for the HI/LO register pair.
//  It accepts MULT/MULTU/DIV/DIVU from EX, iterates, then issues a single-cycle write (hilo_we, hi_o, lo_o).
//  That write goes to the HI/LO register write port. busy stalls the pipeline while an operation is in flight.
// PARAMETERS
//  WIDTH    32  operand width; HI and LO are each WIDTH bits.
//  CNT_W    6   iteration counter width; must satisfy 2**CNT_W > WIDTH.
// PORTS
//  clk        in   1      clock; all state updates on posedge.
//  rst        in   1      asynchronous reset, active-high.
//  start      in   1      request; sampled only in IDLE.
//  op         in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
//  src_a      in   WIDTH  multiplicand / dividend.
//  src_b      in   WIDTH  multiplier / divisor.
//  flush      in   1      cancel the in-flight operation (exception / pipeline flush).
//  busy       out  1      high while state != IDLE.
//  hilo_we    out  1      one-cycle write strobe toward HI/LO.
//  hi_o       out  WIDTH  HI result (product[2W-1:W] / remainder).
//  lo_o       out  WIDTH  LO result (product[W-1:0] / quotient).
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, hilo_we=0, hi_o=0, lo_o=0; counter and internal datapath cleared.
//  - States: IDLE -> RUN on start&!flush. RUN -> DONE when count==WIDTH-1. DONE -> IDLE unconditionally.
//  - Start latch: op, |src_a|, |src_b| and the sign bits are latched on the accepting edge. Signed ops only (MULT/DIV) take abs values.
//  - Ignored requests: start in RUN or DONE is ignored and not queued.
//  - RUN: one radix-2 step per cycle, WIDTH cycles total.
//    - Multiply: shift-add into a 2*WIDTH accumulator.
//    - Divide: restoring shift-subtract; remainder is WIDTH+1 bits to hold the carry.
//  - DONE: sign fix-up, then drive hi_o/lo_o and hilo_we=1 for exactly this one cycle.
//    - MULT: negate the 2W product if sign_a^sign_b.
//    - DIV: negate quotient if sign_a^sign_b; remainder takes sign of dividend.
//  - Latency: start accepted at edge N -> hilo_we high in cycle N+WIDTH+1 (33 for WIDTH=32). busy is high in that cycle.
//  - hi_o/lo_o hold their last value after DONE until the next result; only hilo_we qualifies them.
//  - Divide by zero (src_b==0): no trap. The full iteration runs, then result is lo_o={WIDTH{1'b1}}, hi_o=dividend.
//    - "dividend" means the raw, unsigned-abs-reversed src_a; for DIV, hi_o=src_a as given.
//  - Corner: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no overflow flag).
//  - flush: any state -> IDLE on the next edge. hilo_we stays 0 that cycle; hi_o/lo_o are unchanged.
//    - flush in DONE suppresses the write.
//    - flush with start in the same cycle: flush wins and start is dropped.
//  - Async rst mid-operation: immediate return to reset values; no partial write is ever emitted.
// CONFIGURATION
//  MULDIV_FAST_MULT_EN
//   - Defined: MULT/MULTU compute with a combinational WIDTH x WIDTH multiply registered at the accept edge.
//     FSM goes IDLE -> DONE directly and hilo_we rises in cycle N+1. DIV/DIVU are unchanged (iterative).
//   - Undefined: all four ops are iterative, WIDTH+1 cycle latency. No hardware multiplier is inferred.
//   - Sign, flush and reset rules are identical in both builds.
// TESTING
//  1. rst pulse between edges -> busy/hilo_we/hi_o/lo_o read 0 immediately, before the next clk edge.
//  2. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hilo_we 1 cycle at N+33 (N+1 fast); hi=0xFFFFFFFE, lo=0x00000001.
//  3. MULT 0xFFFFFFFE(-2)*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  4. DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064 at N+33. A second start at N+5 is ignored (one write only).
//  5. DIVU 100/7, flush at N+10 -> busy low by N+11, no hilo_we. A new start at N+12 completes normally (lo=14, hi=2).
//  6. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. flush asserted in the DONE cycle -> hilo_we stays 0.

Source files
------------

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: radix-2 MIPS MULT/MULTU/DIV/DIVU engine that drives the HI/LO write port.
// Build option MULDIV_FAST_MULT_EN: multiplies use a combinational multiplier and finish in one cycle.
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  // Multiply: full product accumulator. Divide: low half holds dividend shifting out / quotient in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               in_signed, res_signed, res_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    in_signed = ~op[0];
    a_abs     = (in_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    b_abs     = (in_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  end

  // Datapath for one iteration; the shifted remainder keeps its carry so the compare is exact.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[WIDTH-1:0] - b_q;
  end

  always_comb begin
    res_signed = ~op_q[0];
    res_neg    = res_signed & (sign_a_q ^ sign_b_q);
    prod_fix   = res_neg ? -acc_q : acc_q;
    if (op_q[1]) begin
      res_lo = (b_q == '0) ? '1 : (res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      res_hi = (res_signed && sign_a_q) ? -rem_q : rem_q;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d  = RUN;
          cnt_d    = '0;
          op_d     = op;
          sign_a_d = in_signed & src_a[WIDTH-1];
          sign_b_d = in_signed & src_b[WIDTH-1];
          a_d      = a_abs;
          b_d      = b_abs;
          rem_d    = '0;
          acc_d    = op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
`ifdef MULDIV_FAST_MULT_EN
          if (!op[1]) begin
            acc_d   = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          rem_d             = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_d[WIDTH-1:0]  = {acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // The result is shown live in DONE; afterwards the captured copy holds until the next write.
  always_comb begin
    busy    = (state_q != IDLE);
    hilo_we = (state_q == DONE) && !flush;
    hi_o    = hilo_we ? res_hi : hi_q;
    lo_o    = hilo_we ? res_lo : lo_q;
  end
endmodule
